// File: rtl/wts_ram.sv
// Wave-table RAM: DEPTH x DW single-port, read-first, out-of-range reads return 0.
// Latency: 1-cycle registered read; no backpressure, one operation accepted every cycle.
module wts_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sram_we,
    input  logic [AW-1:0] sram_a,
    input  logic [DW-1:0] sram_d,
    output logic [DW-1:0] sram_q
);

    localparam int unsigned DEPTH_U = DEPTH;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic          in_range;
    logic          wr_en;

    // Addresses past DEPTH are decoded out explicitly so they never alias onto real rows.
    assign in_range = (32'(sram_a) < DEPTH_U);
    assign wr_en    = sram_we && in_range && !reset;

    // Array has no reset so it maps onto block RAM and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[sram_a] <= sram_d;
        end
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_q <= '0;
        end else if (in_range) begin
            sram_q <= mem[sram_a];
        end else begin
            sram_q <= '0;
        end
    end

endmodule

// File: tb/tb_wts_ram.sv
// Scoreboard bench for wts_ram: reference array with read-first, 1-cycle read latency.
module tb_wts_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       sram_we;
    logic [9:0] sram_a;
    logic [7:0] sram_d;
    logic [7:0] sram_q;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] exp;
        bit         known;
    } sb_item_t;

    sb_item_t   sb[$];
    logic [7:0] ref_mem [0:639];
    bit         ref_ok  [0:639];
    string      phase;

    wts_ram #(.DEPTH(640), .AW(10), .DW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .sram_we (sram_we),
        .sram_a  (sram_a),
        .sram_d  (sram_d),
        .sram_q  (sram_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: expectation is queued from the model before the edge, compared after it.
    task automatic step(input bit rst, input bit we, input logic [9:0] a, input logic [7:0] d);
        sb_item_t it;
        reset   = rst;
        sram_we = we;
        sram_a  = a;
        sram_d  = d;
        if (rst || a >= 10'd640) begin
            it.exp   = 8'h00;
            it.known = 1'b1;
        end else begin
            it.exp   = ref_mem[a];
            it.known = ref_ok[a];
        end
        sb.push_back(it);
        @(posedge clk);
        #1;
        if (!rst && we && a < 10'd640) begin
            ref_mem[a] = d;
            ref_ok[a]  = 1'b1;
        end
        it = sb.pop_front();
        if (it.known) check(phase, sram_q, it.exp);
    endtask

    initial begin
        logic [9:0] ra;
        for (int i = 0; i < 640; i++) ref_ok[i] = 1'b0;
        reset   = 1'b1;
        sram_we = 1'b0;
        sram_a  = '0;
        sram_d  = '0;

        phase = "reset_state";
        step(1, 0, 10'd0, 8'h00);
        step(1, 0, 10'd3, 8'h00);

        phase = "fill";
        for (int i = 0; i < 640; i++) step(0, 1, 10'(i), 8'((i + 100) & 255));

        phase = "readback";
        for (int i = 0; i < 640; i++) step(0, 0, 10'(i), 8'($urandom));
        step(0, 0, 10'd0, 8'($urandom));
        check("ex_addr0", sram_q, 8'd100);
        step(0, 0, 10'd155, 8'($urandom));
        check("ex_addr155", sram_q, 8'd255);
        step(0, 0, 10'd156, 8'($urandom));
        check("ex_addr156", sram_q, 8'd0);
        step(0, 0, 10'd639, 8'($urandom));
        check("ex_addr639", sram_q, 8'd227);

        phase = "collision";
        step(0, 1, 10'd5, 8'h11);
        step(0, 1, 10'd5, 8'h22);
        check("rd_first_old", sram_q, 8'h11);
        step(0, 0, 10'd5, 8'h00);
        check("rd_after_wr", sram_q, 8'h22);

        phase = "out_of_range";
        step(0, 1, 10'd640, 8'hAA);
        step(0, 1, 10'd1023, 8'hAA);
        step(0, 0, 10'd0, 8'h00);
        check("oor_no_alias0", sram_q, 8'd100);
        step(0, 0, 10'd640, 8'h00);
        check("oor_rd640", sram_q, 8'h00);
        step(0, 0, 10'd1023, 8'h00);
        check("oor_rd1023", sram_q, 8'h00);
        step(0, 0, 10'd128, 8'h00);
        check("oor_no_alias128", sram_q, 8'd228);

        phase = "reset_mid";
        step(1, 0, 10'd10, 8'h00);
        check("rst_q0_a", sram_q, 8'h00);
        step(1, 0, 10'd10, 8'h00);
        check("rst_q0_b", sram_q, 8'h00);
        step(0, 0, 10'd10, 8'h00);
        check("rst_retained", sram_q, 8'd110);

        phase = "reset_vs_write";
        step(1, 1, 10'd20, 8'h55);
        check("rst_wr_q0", sram_q, 8'h00);
        step(0, 0, 10'd20, 8'h00);
        check("rst_wr_dropped", sram_q, 8'd120);

        phase = "random";
        for (int n = 0; n < 10000; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 10'($urandom_range(0, 7));
                1:       ra = 10'($urandom_range(630, 1023));
                default: ra = 10'($urandom_range(0, 1023));
            endcase
            step(($urandom_range(0, 99) == 0), bit'($urandom_range(0, 1)), ra, 8'($urandom));
        end

        phase = "drain";
        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
